// File: rtl/l2_port_responder.sv
// L1-to-L2 line port responder: one-entry write-back buffer drained to physical memory in the background.
// Optional build macro L2RESP_FORWARD_EN serves reads that hit the buffered line directly from the buffer.
module l2_port_responder (
    input  logic         clk,
    input  logic         reset,
    input  logic         L2_read,
    input  logic         L2_write,
    input  logic [15:0]  L2_address,
    input  logic [127:0] L2_wdata,
    output logic         L2_resp,
    output logic [127:0] L2_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESP       = 2'd1,
        FILL       = 2'd2,
        WAIT_DRAIN = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic           wb_valid_r, wb_valid_s;
    logic [11:0]    wb_tag_r, wb_tag_s;
    logic [127:0]   wb_data_r, wb_data_s;
    logic [127:0]   rdata_s;
    logic [15:0]    pmem_address_s;
    logic           drain_done_s;
    logic           fill_done_s;
    logic           unused_s;

    // Line offset bits never reach memory.
    assign unused_s     = ^L2_address[3:0];
    // Completion only counts against a request we are actually holding.
    assign drain_done_s = pmem_write & pmem_resp;
    assign fill_done_s  = pmem_read & pmem_resp;

    // Next-state, buffer and read-data decode.
    always_comb begin
        state_s   = state_r;
        wb_tag_s  = wb_tag_r;
        wb_data_s = wb_data_r;
        rdata_s   = L2_rdata;
        if (drain_done_s) begin
            wb_valid_s = 1'b0;
        end else begin
            wb_valid_s = wb_valid_r;
        end

        case (state_r)
            IDLE: begin
                // A drain finishing this very cycle defers the decision by one cycle.
                if (L2_write) begin
                    if (!wb_valid_r) begin
                        wb_valid_s = 1'b1;
                        wb_tag_s   = L2_address[15:4];
                        wb_data_s  = L2_wdata;
                        state_s    = RESP;
                    end else if (drain_done_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT_DRAIN;
                    end
                end else if (L2_read) begin
                    if (!wb_valid_r) begin
                        state_s = FILL;
                    end
`ifdef L2RESP_FORWARD_EN
                    else if (wb_tag_r == L2_address[15:4]) begin
                        rdata_s = wb_data_r;
                        state_s = RESP;
                    end
`endif
                    else if (drain_done_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT_DRAIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            FILL: begin
                if (fill_done_s) begin
                    rdata_s = pmem_rdata;
                    state_s = RESP;
                end else begin
                    state_s = FILL;
                end
            end
            WAIT_DRAIN: begin
                if (drain_done_s || !wb_valid_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (state_s == FILL) begin
            pmem_address_s = {L2_address[15:4], 4'h0};
        end else if (wb_valid_s) begin
            pmem_address_s = {wb_tag_s, 4'h0};
        end else begin
            pmem_address_s = 16'h0000;
        end
    end

    // State, buffer and registered port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            wb_valid_r   <= 1'b0;
            wb_tag_r     <= 12'h000;
            wb_data_r    <= 128'h0;
            L2_resp      <= 1'b0;
            L2_rdata     <= 128'h0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= 16'h0000;
            pmem_wdata   <= 128'h0;
        end else begin
            state_r      <= state_s;
            wb_valid_r   <= wb_valid_s;
            wb_tag_r     <= wb_tag_s;
            wb_data_r    <= wb_data_s;
            L2_resp      <= (state_s == RESP);
            L2_rdata     <= rdata_s;
            pmem_read    <= (state_s == FILL);
            pmem_write   <= wb_valid_s & (state_s != FILL);
            pmem_address <= pmem_address_s;
            pmem_wdata   <= wb_data_s;
        end
    end

endmodule

// File: tb/tb_l2_port_responder.sv
// Scoreboard bench for l2_port_responder: expected L2 responses and memory transactions are queued
// at issue time and checked by independent monitor / memory-model processes.
module tb_l2_port_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         L2_read, L2_write;
    logic [15:0]  L2_address;
    logic [127:0] L2_wdata;
    logic         L2_resp;
    logic [127:0] L2_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    l2_port_responder dut (
        .clk(clk), .reset(reset),
        .L2_read(L2_read), .L2_write(L2_write), .L2_address(L2_address), .L2_wdata(L2_wdata),
        .L2_resp(L2_resp), .L2_rdata(L2_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { int lat; logic [127:0] rdata; } l2_exp_t;
    typedef struct { bit wr; logic [15:0] addr; logic [127:0] data; } pm_exp_t;

    l2_exp_t exp_q[$];
    pm_exp_t pm_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int req_cyc = 0;
    int mem_delay = 3;
    bit mem_busy = 1'b0;
    logic [127:0] last_rd = 128'h0;

    localparam logic [127:0] D_A5   = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [127:0] D_DEAD = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    localparam logic [127:0] D_W1   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D_W2   = 128'h20002000_CAFEF00D_0BADC0DE_20002000;
    localparam logic [127:0] D_W3   = 128'h33333333_00000000_FFFFFFFF_33333333;
    localparam logic [127:0] D_W5   = 128'h55555555_55555555_AAAAAAAA_AAAAAAAA;
    localparam logic [127:0] D_W7   = 128'h77770000_77770000_77770000_77770000;
    localparam logic [127:0] D_R8   = 128'h88888888_12345678_87654321_88888888;
    localparam logic [127:0] D_W9   = 128'h99999999_99999999_99999999_99999999;
    localparam logic [127:0] D_RA   = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request (caller is just after a posedge) and hold it until L2_resp is seen.
    task automatic request(input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [127:0] wd, input int lat, input logic [127:0] exp_rd);
        l2_exp_t e;
        int n;
        e.lat = lat;
        e.rdata = exp_rd;
        exp_q.push_back(e);
        req_cyc = cyc;
        L2_read = rd;
        L2_write = wr;
        L2_address = addr;
        L2_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!L2_resp && n < 100);
        if (!L2_resp) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_timeout: no L2_resp for addr %h after %0d cycles, required one", addr, n);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        L2_read = 1'b0;
        L2_write = 1'b0;
    endtask

    // Wait for all outstanding traffic to drain, bounded.
    task automatic settle();
        int n;
        n = 0;
        while ((pm_q.size() != 0 || exp_q.size() != 0 || pmem_read || pmem_write || mem_busy) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL settle_timeout: pending pmem %0d / l2 %0d, required 0 / 0", pm_q.size(), exp_q.size());
            pm_q.delete();
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic push_pm(input bit wr, input logic [15:0] addr, input logic [127:0] data);
        pm_exp_t p;
        p.wr = wr;
        p.addr = addr;
        p.data = data;
        pm_q.push_back(p);
    endtask

    // L2 response monitor.
    always @(negedge clk) begin
        if (!reset && L2_resp) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_l2_resp: got L2_resp=1 with rdata %h, required none", L2_rdata);
            end else begin
                l2_exp_t e;
                e = exp_q.pop_front();
                check("l2_resp_latency", 128'(cyc - req_cyc), 128'(e.lat));
                check("l2_rdata", L2_rdata, e.rdata);
            end
        end
    end

    // Physical memory model: checks each transaction against the queue and answers after mem_delay.
    initial begin
        bit post_chk;
        bit post_wr;
        pm_exp_t p;
        pmem_resp = 1'b0;
        pmem_rdata = 128'h0;
        post_chk = 1'b0;
        post_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (post_chk) begin
                post_chk = 1'b0;
                if (post_wr) check("pmem_write_drop", 128'(pmem_write), 128'h0);
                else         check("pmem_read_drop", 128'(pmem_read), 128'h0);
            end
            if (!reset && (pmem_read || pmem_write)) begin
                mem_busy = 1'b1;
                check("pmem_exclusive", 128'(pmem_read & pmem_write), 128'h0);
                if (pm_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pmem: got rd=%0b wr=%0b addr %h, required no access", pmem_read, pmem_write, pmem_address);
                    p.wr = pmem_write;
                    p.addr = pmem_address;
                    p.data = 128'h0;
                end else begin
                    p = pm_q.pop_front();
                    check("pmem_is_write", 128'(pmem_write), 128'(p.wr));
                    check("pmem_address", 128'(pmem_address), 128'(p.addr));
                    if (p.wr) check("pmem_wdata", pmem_wdata, p.data);
                end
                repeat (mem_delay) @(posedge clk);
                #1;
                pmem_resp = 1'b1;
                pmem_rdata = p.wr ? 128'h0 : p.data;
                @(posedge clk);
                #1;
                pmem_resp = 1'b0;
                post_chk = 1'b1;
                post_wr = p.wr;
                mem_busy = 1'b0;
            end
        end
    end

    initial begin
        reset = 1'b1;
        L2_read = 1'b0;
        L2_write = 1'b0;
        L2_address = 16'h0000;
        L2_wdata = 128'h0;
        tick(2);
        @(negedge clk);
        check("rst_l2_resp", 128'(L2_resp), 128'h0);
        check("rst_l2_rdata", L2_rdata, 128'h0);
        check("rst_pmem_read", 128'(pmem_read), 128'h0);
        check("rst_pmem_write", 128'(pmem_write), 128'h0);
        check("rst_pmem_address", 128'(pmem_address), 128'h0);
        check("rst_pmem_wdata", pmem_wdata, 128'h0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // Reset in the middle of a fill aborts it; the late pmem_resp is ignored.
        mem_delay = 8;
        push_pm(1'b0, 16'h6000, D_RA);
        L2_read = 1'b1;
        L2_address = 16'h6004;
        @(negedge clk);
        @(negedge clk);
        check("fill_started", 128'(pmem_read), 128'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        L2_read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_pmem_read", 128'(pmem_read), 128'h0);
        check("abort_l2_resp", 128'(L2_resp), 128'h0);
        tick(14);
        last_rd = 128'h0;
        settle();

        // Write with empty buffer: 1-cycle response, background drain.
        mem_delay = 3;
        push_pm(1'b1, 16'h1230, D_A5);
        request(1'b0, 1'b1, 16'h1234, D_A5, 1, last_rd);
        settle();

        // Write then read of the same line before the drain completes.
        mem_delay = 4;
        push_pm(1'b1, 16'h2000, D_W2);
        request(1'b0, 1'b1, 16'h2000, D_W2, 1, last_rd);
`ifdef L2RESP_FORWARD_EN
        request(1'b1, 1'b0, 16'h200E, 128'h0, 1, D_W2);
`else
        push_pm(1'b0, 16'h2000, D_W2);
        request(1'b1, 1'b0, 16'h200E, 128'h0, 10, D_W2);
`endif
        last_rd = D_W2;
        settle();

        // Read miss, buffer empty, memory answers after 5 cycles.
        mem_delay = 5;
        push_pm(1'b0, 16'h4000, D_DEAD);
        request(1'b1, 1'b0, 16'h4000, 128'h0, 7, D_DEAD);
        last_rd = D_DEAD;
        settle();

        // Second write waits for the first drain, then drains itself.
        mem_delay = 4;
        push_pm(1'b1, 16'h1000, D_W1);
        push_pm(1'b1, 16'h3000, D_W3);
        request(1'b0, 1'b1, 16'h1000, D_W1, 1, last_rd);
        request(1'b0, 1'b1, 16'h3000, D_W3, 5, last_rd);
        settle();

        // Read of a different line while the buffer drains.
        mem_delay = 2;
        push_pm(1'b1, 16'h7000, D_W7);
        push_pm(1'b0, 16'h8000, D_R8);
        request(1'b0, 1'b1, 16'h7000, D_W7, 1, last_rd);
        request(1'b1, 1'b0, 16'h8008, 128'h0, 6, D_R8);
        last_rd = D_R8;
        settle();

        // Drain completes in the same cycle the read arrives.
        mem_delay = 1;
        push_pm(1'b1, 16'h9000, D_W9);
        push_pm(1'b0, 16'hA000, D_RA);
        request(1'b0, 1'b1, 16'h9000, D_W9, 1, last_rd);
        request(1'b1, 1'b0, 16'hA000, 128'h0, 4, D_RA);
        last_rd = D_RA;
        settle();

        // Read and write together: write wins, no memory read.
        mem_delay = 3;
        push_pm(1'b1, 16'h5000, D_W5);
        request(1'b1, 1'b1, 16'h5000, D_W5, 1, last_rd);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_port_responder.md
# l2_port_responder

Responder for the L1-to-L2 line port driven by the data cache's miss/write-back controller. Answers line reads and line write-backs from a one-entry write-back buffer and physical memory, so an L1 write-back completes in one cycle while the line drains to memory in the background. Sits between the L1 data cache and the physical-memory line port.

## Interface
- No parameters. Line width is 128 bits (lc3b_L1_line); address is 16 bits (lc3b_word); line index is address[15:4].
- clk  input  1  system clock; one clock, all state on its rising edge
- reset  input  1  synchronous, active-high reset
- L2_read  input  1  line read request; held until L2_resp seen
- L2_write  input  1  line write request; held until L2_resp seen
- L2_address  input  16  request address; bits [3:0] ignored
- L2_wdata  input  128  write line, valid with L2_write
- L2_resp  output  1  one-cycle completion pulse
- L2_rdata  output  128  read line, valid while L2_resp high
- pmem_read  output  1  memory line read; held until pmem_resp
- pmem_write  output  1  memory line write; held until pmem_resp
- pmem_address  output  16  line address, bits [3:0] = 0
- pmem_wdata  output  128  drain data, stable while pmem_write high
- pmem_resp  input  1  memory completion pulse
- pmem_rdata  input  128  memory read line, valid with pmem_resp

## Operation
- Buffer state: wb_valid, wb_tag[11:0], wb_data[127:0].
- States: IDLE, RESP, FILL, WAIT_DRAIN.
- IDLE, L2_write: if !wb_valid, capture tag/data, set wb_valid, go RESP. If wb_valid, go WAIT_DRAIN (no coalescing; the drain is never modified mid-flight).
- IDLE, L2_read: if wb_valid and tag match, load L2_rdata from wb_data, go RESP. If wb_valid and no match, go WAIT_DRAIN. If !wb_valid, go FILL.
- WAIT_DRAIN: on drain completion, re-evaluate the held request as from IDLE with empty buffer.
- FILL: pmem_read high, pmem_address = {L2_address[15:4],4'b0}; on pmem_resp latch pmem_rdata into L2_rdata, go RESP.
- RESP: L2_resp high exactly one cycle; back to IDLE. The request is not re-sampled in RESP (requester drops it the next cycle).
- Drain: whenever wb_valid and state != FILL, pmem_write high, pmem_address = {wb_tag,4'b0}, pmem_wdata = wb_data; pmem_resp clears wb_valid. pmem_read and pmem_write are never high together.
- L2_read and L2_write both high: illegal; write takes priority, read ignored.
- pmem_resp with neither pmem_read nor pmem_write high: ignored.
- L2_rdata holds its last value until the next read completes.

## Timing
- Reset: all outputs 0, state IDLE, wb_valid 0, wb_tag/wb_data 0. Reset mid-operation aborts any fill or drain; buffered line is discarded.
- Write, buffer empty: request in cycle t, L2_resp in t+1; pmem_write high from t+1.
- Read forwarded from buffer: request t, L2_resp t+1.
- Read miss, buffer empty: request t, pmem_read from t+1; pmem_resp in u, L2_resp in u+1.
- Request with buffer busy: waits for drain pmem_resp (cycle d), is re-evaluated in d+1, then follows the rows above.
- Drain starts in the cycle after wb_valid sets, even when a new request arrives in the same cycle.

## Configuration
- L2RESP_FORWARD_EN defined: read whose line matches a valid buffer entry is served from the buffer (1-cycle).
- Undefined: every read with wb_valid set goes through WAIT_DRAIN, then FILL from memory; no buffer compare logic.

## Test plan
- Reset mid-FILL (pmem_read high) -> next cycle pmem_read 0, L2_resp 0, later pmem_resp ignored, no L2_resp.
- L2_write addr 0x1234, data 0xA5..A5, buffer empty -> L2_resp at t+1; pmem_write from t+1 with pmem_address 0x1230, data 0xA5..A5; wb_valid clears on pmem_resp.
- Write 0x2000, then read 0x200E before drain completes -> with macro: L2_resp one cycle after read, L2_rdata = written line, no pmem_read; without macro: pmem_read 0x2000 only after drain pmem_resp.
- Read 0x4000, buffer empty, pmem_resp after 5 cycles with 0xDEAD..BEEF -> L2_resp one cycle after pmem_resp, L2_rdata = 0xDEAD..BEEF.
- Write 0x1000 then write 0x3000 while draining -> second L2_resp only after first drain pmem_resp + 1 cycle; second drain to 0x3000 follows.
- L2_read and L2_write high together at 0x5000 -> treated as write, no pmem_read issued.
